// File: rtl/demux_rr_dispatcher_pkg.sv
// rtl/demux_rr_dispatcher_pkg.sv - shared encodings and sizes for the round-robin bit dispatcher
package demux_rr_dispatcher_pkg;

    localparam int NUM_SINKS = 8;
    localparam int KEY_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PULSE = 2'd2
    } state_t;

    // Round-robin successor of a destination; wraps naturally at NUM_SINKS
    function automatic logic [KEY_W-1:0] next_ptr(input logic [KEY_W-1:0] k);
        return k + KEY_W'(1);
    endfunction

endpackage

// File: rtl/demux_rr_dispatcher_demux_3x1.sv
// rtl/demux_rr_dispatcher_demux_3x1.sv - 1-to-8 single-bit demultiplexer with enable
module demux_3x1
    import demux_rr_dispatcher_pkg::*;
(
    input  logic             data,
    input  logic [KEY_W-1:0] key,
    input  logic             enable,
    output logic             out1,
    output logic             out2,
    output logic             out3,
    output logic             out4,
    output logic             out5,
    output logic             out6,
    output logic             out7,
    output logic             out8
);

    logic [NUM_SINKS-1:0] sel;

    // Route data to the keyed output only while enabled; everything else stays low
    always_comb begin
        sel = '0;
        if (enable) begin
            sel[key] = data;
        end
    end

    assign out1 = sel[0];
    assign out2 = sel[1];
    assign out3 = sel[2];
    assign out4 = sel[3];
    assign out5 = sel[4];
    assign out6 = sel[5];
    assign out7 = sel[6];
    assign out8 = sel[7];

endmodule

// File: rtl/demux_rr_dispatcher.sv
// rtl/demux_rr_dispatcher.sv - accepts bits, picks a sink (round-robin or explicit), pulses the demux once
module demux_rr_dispatcher
    import demux_rr_dispatcher_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_data,
    input  logic                 in_mode,
    input  logic [KEY_W-1:0]     in_dest,
    output logic                 in_ready,
    input  logic [NUM_SINKS-1:0] sink_ready,
    output logic [NUM_SINKS-1:0] out,
    output logic [KEY_W-1:0]     key,
    output logic                 enable,
    output logic [KEY_W-1:0]     rr_ptr,
    output logic [CNT_W-1:0]     delivered,
    output logic [CNT_W-1:0]     dropped,
    output logic                 timeout_pulse
);

    // Last wait_cnt value before a drop; unused when TIMEOUT is 0
    localparam logic [CNT_W-1:0] WAIT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             data_q;
    logic             mode_q;
    logic [CNT_W-1:0] wait_cnt;

    assign in_ready = (state == ST_IDLE);

    // Sequencer: accept, wait for the chosen sink (or give up), then one enable cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            data_q        <= 1'b0;
            mode_q        <= 1'b0;
            key           <= '0;
            enable        <= 1'b0;
            rr_ptr        <= '0;
            wait_cnt      <= '0;
            delivered     <= '0;
            dropped       <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_data;
                        mode_q   <= in_mode;
                        key      <= in_mode ? in_dest : rr_ptr;
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A ready sink on the final wait cycle still gets the word
                    if (sink_ready[key]) begin
                        enable <= 1'b1;
                        state  <= ST_PULSE;
                    end else if (TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
                        timeout_pulse <= 1'b1;
                        if (dropped != '1) begin
                            dropped <= dropped + CNT_W'(1);
                        end
                        if (!mode_q) begin
                            rr_ptr <= next_ptr(key);
                        end
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_PULSE: begin
                    enable <= 1'b0;
                    if (delivered != '1) begin
                        delivered <= delivered + CNT_W'(1);
                    end
                    if (!mode_q) begin
                        rr_ptr <= next_ptr(key);
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    demux_3x1 u_demux (
        .data   (data_q),
        .key    (key),
        .enable (enable),
        .out1   (out[0]),
        .out2   (out[1]),
        .out3   (out[2]),
        .out4   (out[3]),
        .out5   (out[4]),
        .out6   (out[5]),
        .out7   (out[6]),
        .out8   (out[7])
    );

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// tb/tb_demux_rr_dispatcher.sv - scoreboard bench for demux_rr_dispatcher
module tb_demux_rr_dispatcher;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_data = 1'b0;
    logic       in_mode = 1'b0;
    logic [2:0] in_dest = '0;
    logic       in_ready;
    logic [7:0] sink_ready = '0;
    logic [7:0] out;
    logic [2:0] key;
    logic       enable;
    logic [2:0] rr_ptr;
    logic [CNT_W-1:0] delivered;
    logic [CNT_W-1:0] dropped;
    logic       timeout_pulse;

    demux_rr_dispatcher #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_mode       (in_mode),
        .in_dest       (in_dest),
        .in_ready      (in_ready),
        .sink_ready    (sink_ready),
        .out           (out),
        .key           (key),
        .enable        (enable),
        .rr_ptr        (rr_ptr),
        .delivered     (delivered),
        .dropped       (dropped),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] k;
        logic       d;
    } deliv_t;

    deliv_t     dq[$];
    logic [2:0] drq[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_on = 1'b0;

    // Reference model state
    int m_rr   = 0;
    int m_del  = 0;
    int m_drop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic junk_inputs();
        in_valid = 1'($urandom);
        in_data  = 1'($urandom);
        in_mode  = 1'($urandom);
        in_dest  = 3'($urandom);
    endtask

    task automatic model_reset();
        m_rr   = 0;
        m_del  = 0;
        m_drop = 0;
    endtask

    // delay = number of WAIT cycles with the chosen sink not ready; delay >= TIMEOUT means drop
    task automatic send_word(input bit mode, input logic [2:0] dest, input bit data, input int delay);
        logic [2:0] k;
        logic [7:0] b;
        int budget;
        deliv_t e;
        budget = 0;
        while (in_ready !== 1'b1 && budget < 50) begin
            tick();
            budget++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        k = mode ? dest : 3'(m_rr);
        b = 8'd1 << k;
        in_valid   = 1'b1;
        in_data    = data;
        in_mode    = mode;
        in_dest    = dest;
        sink_ready = 8'($urandom) & ~b;
        if (delay < TIMEOUT) begin
            e.k = k;
            e.d = data;
            dq.push_back(e);
        end else begin
            drq.push_back(k);
        end
        tick();
        for (int i = 0; i < delay && i < TIMEOUT; i++) begin
            junk_inputs();
            sink_ready = 8'($urandom) & ~b;
            chk("in_ready_wait", 32'(in_ready), 32'd0);
            chk("enable_wait", 32'(enable), 32'd0);
            chk("key_wait", 32'(key), 32'(k));
            tick();
        end
        if (delay < TIMEOUT) begin
            junk_inputs();
            sink_ready = 8'($urandom) | b;
            chk("in_ready_wait", 32'(in_ready), 32'd0);
            chk("key_wait", 32'(key), 32'(k));
            tick();
            chk("enable_latency", 32'(enable), 32'd1);
            chk("no_drop_on_deliver", 32'(timeout_pulse), 32'd0);
            in_valid   = 1'b0;
            sink_ready = 8'($urandom);
            tick();
            if (m_del < CNT_MAX) m_del++;
            if (!mode) m_rr = (k + 1) % 8;
        end else begin
            in_valid = 1'b0;
            chk("timeout_pulse", 32'(timeout_pulse), 32'd1);
            if (m_drop < CNT_MAX) m_drop++;
            if (!mode) m_rr = (k + 1) % 8;
        end
        in_valid = 1'b0;
        chk("enable_after", 32'(enable), 32'd0);
        chk("rr_ptr", 32'(rr_ptr), 32'(m_rr));
        chk("delivered", 32'(delivered), 32'(m_del));
        chk("dropped", 32'(dropped), 32'(m_drop));
        chk("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out"}, 32'(out), 32'd0);
        chk({tag, "_key"}, 32'(key), 32'd0);
        chk({tag, "_enable"}, 32'(enable), 32'd0);
        chk({tag, "_rr_ptr"}, 32'(rr_ptr), 32'd0);
        chk({tag, "_delivered"}, 32'(delivered), 32'd0);
        chk({tag, "_dropped"}, 32'(dropped), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout_pulse), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Monitor: every enable or timeout pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (mon_on) begin
            if (enable === 1'b1) begin
                if (dq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_enable: got key %0d out %0h expected no pulse", key, out);
                end else begin
                    deliv_t e;
                    e = dq.pop_front();
                    chk("pulse_key", 32'(key), 32'(e.k));
                    chk("pulse_out", 32'(out), 32'(8'(e.d) << e.k));
                end
            end else begin
                chk("out_quiet", 32'(out), 32'd0);
            end
            if (timeout_pulse === 1'b1) begin
                if (drq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_timeout: got key %0d expected no drop", key);
                end else begin
                    chk("drop_key", 32'(key), 32'(drq.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pattern;
        int r;
        int dly;
        pattern = 8'b0100_1101;

        reset = 1'b1;
        tick();
        mon_on = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_all_zero("reset");

        // Round-robin sweep over all eight sinks, wraps the pointer
        for (int i = 0; i < 8; i++) send_word(1'b0, 3'd0, pattern[i], 0);

        // Explicit destination 5 stalled four cycles
        send_word(1'b1, 3'd5, 1'b1, 4);

        // Advance pointer to 3, then let that word time out
        for (int i = 0; i < 3; i++) send_word(1'b0, 3'd0, 1'b1, 0);
        send_word(1'b0, 3'd0, 1'b1, TIMEOUT);

        // Sink becomes ready on exactly the timeout cycle
        send_word(1'b0, 3'd0, 1'b1, TIMEOUT - 1);

        // Reset while waiting
        in_valid = 1'b1; in_data = 1'b1; in_mode = 1'b0; sink_ready = 8'h00;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        chk_all_zero("rst_wait");
        tick();
        chk_all_zero("rst_wait_after");

        // Reset during the pulse cycle
        begin
            deliv_t e;
            e.k = 3'd0;
            e.d = 1'b1;
            dq.push_back(e);
        end
        in_valid = 1'b1; in_data = 1'b1; in_mode = 1'b0; sink_ready = 8'hFF;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rst_pulse_enable", 32'(enable), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        chk_all_zero("rst_pulse");
        tick();
        chk_all_zero("rst_pulse_after");

        // Randomized traffic, long enough to saturate the delivered counter
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 15));
            if (r == 15)      dly = TIMEOUT + int'($urandom_range(0, 1));
            else if (r == 14) dly = TIMEOUT - 1;
            else              dly = r % 4;
            send_word(1'($urandom), 3'($urandom), 1'($urandom), dly);
        end
        chk("delivered_saturated", 32'(delivered), 32'(CNT_MAX));

        tick();
        tick();
        chk("deliv_queue_empty", 32'(dq.size()), 32'd0);
        chk("drop_queue_empty", 32'(drq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
